// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 16x oversampled UART receiver feeding the RX FIFO write port.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_deserializer #(
  parameter int DATA_BITS = 8,
  parameter int OSR       = 16
) (
  input  logic                 clkw,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_i,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 fifofull,
  output logic                 fifowr,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 RXdone,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy_o
);

  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] ONE      = TW'(1);
  localparam logic [TW-1:0] M_START  = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] M_BIT    = TW'(OSR - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t               state;
  logic                 rx_m, rx_s, rx_s_d;
  logic [TW-1:0]        tcnt;
  logic [2:0]           bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 pen_q, podd_q, perr_q;
  logic [TW-1:0]        m_idx;
  logic                 decide, bit_v;

  assign m_idx = (state == START) ? M_START : M_BIT;

`ifdef UART_RX_MAJORITY_EN
  // Votes are taken one tick late; the start restart value keeps the data grid unchanged.
  localparam logic [TW-1:0] TCNT_RESTART = ONE;
  logic v_early, v_mid;

  assign decide = baud_tick && (tcnt == m_idx + ONE);
  assign bit_v  = (v_early & v_mid) | (v_early & rx_s) | (v_mid & rx_s);

  always_ff @(posedge clkw or negedge rst_n) begin
    if (!rst_n) begin
      v_early <= 1'b1;
      v_mid   <= 1'b1;
    end else if (baud_tick) begin
      if (tcnt == m_idx - ONE) v_early <= rx_s;
      if (tcnt == m_idx)       v_mid   <= rx_s;
    end
  end
`else
  localparam logic [TW-1:0] TCNT_RESTART = '0;

  assign decide = baud_tick && (tcnt == m_idx);
  assign bit_v  = rx_s;
`endif

  always_ff @(posedge clkw or negedge rst_n) begin
    if (!rst_n) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_s_d      <= 1'b1;
      state       <= IDLE;
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      pen_q       <= 1'b0;
      podd_q      <= 1'b0;
      perr_q      <= 1'b0;
      rx_data_o   <= '0;
      fifowr      <= 1'b0;
      RXdone      <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      rx_m        <= rx_i;
      rx_s        <= rx_m;
      rx_s_d      <= rx_s;
      fifowr      <= 1'b0;
      RXdone      <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      if (baud_tick && state != IDLE && state != BREAK) tcnt <= tcnt + ONE;
      case (state)
        IDLE: begin
          if (rx_s_d && !rx_s) begin
            tcnt   <= '0;
            bcnt   <= '0;
            pen_q  <= parity_en;
            podd_q <= parity_odd;
            perr_q <= 1'b0;
            busy_o <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          if (decide) begin
            if (!bit_v) begin
              tcnt  <= TCNT_RESTART;
              state <= DATA;
            end else begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shreg <= {bit_v, shreg[DATA_BITS-1:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == LAST_BIT) state <= pen_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (decide) begin
            perr_q <= ((^shreg) ^ bit_v) != podd_q;
            state  <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            RXdone <= 1'b1;
            if (!bit_v) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              busy_o <= 1'b0;
              state  <= IDLE;
              if (perr_q) begin
                parity_err <= 1'b1;
              end else if (fifofull) begin
                overrun_err <= 1'b1;
              end else begin
                rx_data_o <= shreg;
                fifowr    <= 1'b1;
              end
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
